// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared owner-state encoding, data-region tag and starvation
//            limit default for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Who owns the memory port in the cycle after an accept
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_CYC = 2'd1,
        ST_DMA_CYC = 2'd2,
        ST_DMA_ERR = 2'd3
    } owner_state_e;

    // Upper address byte that identifies the data memory region
    localparam logic [7:0] DATA_REGION = 8'h00;

    // Consecutive refusals the DMA tolerates before it takes priority
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    // True when a byte address falls inside the data memory region
    function automatic logic is_data_region(input logic [31:0] addr);
        return (addr[31:24] == DATA_REGION);
    endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dmem_starve_cnt
// Purpose  : Counts consecutive cycles the DMA request is refused, saturating
//            at STARVE_LIMIT; cleared on a DMA grant or when DMA stops asking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dma_req,
    input  logic       dma_gnt,
    output logic [3:0] wait_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt_d;
    logic [3:0] wait_cnt_q;

    // Next count: clear when the DMA is served or idle, else saturating +1
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req || dma_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt = wait_cnt_q;

endmodule : dmem_starve_cnt
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-master (CPU, DMA) arbiter in front of a single-port data
//            memory. CPU has priority unless the DMA has been starved for
//            STARVE_LIMIT cycles. Accepted commands are registered and
//            presented to the memory one cycle later; DMA accesses outside
//            the data region are dropped with a one-cycle error pulse.
// Revision : 1.0 - initial release
// ============================================================================
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    // DMA port
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        dma_err,
    // Data memory port
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]   wait_cnt;
    logic         dma_starved;

    owner_state_e state_d, state_q;
    logic [31:0]  addr_d,  addr_q;
    logic [31:0]  wdata_d, wdata_q;
    logic         we_d,    we_q;
    logic         mem_cyc;

    dmem_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .dma_req  (dma_req),
        .dma_gnt  (dma_gnt),
        .wait_cnt (wait_cnt)
    );

    assign dma_starved = (wait_cnt == LIMIT);

    // Grants are combinational; holding them low in reset means a command
    // presented while reset is asserted can never be accepted.
    assign dma_gnt = rst_n & dma_req & (~cpu_req | dma_starved);
    assign cpu_gnt = rst_n & cpu_req & ~(dma_req & dma_starved);

    // Next owner and command capture; a dropped DMA access leaves the
    // previous command registers untouched.
    always_comb begin
        state_d = ST_IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        if (cpu_gnt) begin
            state_d = ST_CPU_CYC;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
        end else if (dma_gnt) begin
            if (is_data_region(dma_addr)) begin
                state_d = ST_DMA_CYC;
                addr_d  = dma_addr;
                wdata_d = dma_wdata;
                we_d    = dma_we;
            end else begin
                state_d = ST_DMA_ERR;
            end
        end
    end

    // Owner state and registered command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Memory strobes only in cycles that actually own the memory
    assign mem_cyc    = (state_q == ST_CPU_CYC) || (state_q == ST_DMA_CYC);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_write  = mem_cyc & we_q;
    assign mem_read   = mem_cyc & ~we_q;

    assign cpu_rvalid = (state_q == ST_CPU_CYC) & ~we_q;
    assign dma_rvalid = (state_q == ST_DMA_CYC) & ~we_q;
    assign dma_err    = (state_q == ST_DMA_ERR);

    assign rdata      = mem_rdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = 32'd0, dma_wdata = 32'd0;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic        mem_write, mem_read;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_err    (dma_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // 1 KB data memory behind the arbiter (address bits [9:2] select a word)
    logic [31:0] bmem [256] = '{default: 32'd0};
    always @(posedge clk) if (mem_write) bmem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = bmem[mem_addr[9:2]];

    // Reference model state
    logic [31:0] mmem [256] = '{default: 32'd0};
    int          starve = 0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_rdata = 32'd0;
    bit          e_wr = 0, e_rd = 0, e_crv = 0, e_drv = 0, e_err = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        starve = 0;
        e_addr = 32'd0; e_wdata = 32'd0;
        e_wr = 0; e_rd = 0; e_crv = 0; e_drv = 0; e_err = 0;
    endtask

    // Check every registered output against the model's expectation
    task automatic check_regs();
        chk("mem_write",  32'(mem_write),  32'(e_wr));
        chk("mem_read",   32'(mem_read),   32'(e_rd));
        chk("mem_addr",   mem_addr,        e_addr);
        chk("mem_wdata",  mem_wdata,       e_wdata);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
        chk("dma_err",    32'(dma_err),    32'(e_err));
        if (e_crv || e_drv) chk("rdata", rdata, e_rdata);
    endtask

    // One clock cycle: drive a request pair, check grants, predict the
    // following cycle from the arbitration rules, then check it.
    task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                        output bit gc, output bit gd);
        bit dwin, ecg, edg;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
        dwin = dr && (!cr || starve == LIMIT);
        ecg  = cr && !dwin;
        edg  = dwin;
        chk("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
        chk("dma_gnt", 32'(dma_gnt), 32'(edg));
        gc = cpu_gnt;
        gd = dma_gnt;
        e_wr = 0; e_rd = 0; e_crv = 0; e_drv = 0; e_err = 0;
        if (ecg) begin
            e_addr = ca; e_wdata = cd; e_wr = cw; e_rd = !cw; e_crv = !cw;
            if (cw) mmem[ca[9:2]] = cd; else e_rdata = mmem[ca[9:2]];
        end else if (edg) begin
            if (da[31:24] == 8'h00) begin
                e_addr = da; e_wdata = dd; e_wr = dw; e_rd = !dw; e_drv = !dw;
                if (dw) mmem[da[9:2]] = dd; else e_rdata = mmem[da[9:2]];
            end else begin
                e_err = 1;
            end
        end
        if (!dr || edg) starve = 0;
        else if (starve < LIMIT) starve = starve + 1;
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic idle();
        bit a, b;
        step(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, a, b);
    endtask

    initial begin
        bit gc, gd;
        logic [9:0] pat;
        logic [31:0] ca, da;

        // Reset state, with both masters already requesting
        cpu_req = 1; dma_req = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        check_regs();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // CPU store then load of 0x10
        step(1, 1, 32'h10, 32'h1234, 0, 0, 32'd0, 32'd0, gc, gd);
        chk("st_write_lit", 32'(mem_write), 32'd1);
        chk("st_addr_lit", mem_addr, 32'h10);
        idle();
        step(1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0, gc, gd);
        chk("ld_rvalid_lit", 32'(cpu_rvalid), 32'd1);
        chk("ld_rdata_lit", rdata, 32'h1234);

        // Both requesting continuously: CPU x4, DMA, CPU x4, DMA
        idle();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h20, 32'd0, 1, 0, 32'h24, 32'd0, gc, gd);
            pat[i] = gd;
        end
        chk("starve_pattern", 32'(pat), 32'h210);

        // DMA write outside the data region is dropped
        idle();
        step(0, 0, 32'd0, 32'd0, 1, 1, 32'h4000_0010, 32'hDEAD, gc, gd);
        chk("err_gnt_lit", 32'(gd), 32'd1);
        chk("err_pulse_lit", 32'(dma_err), 32'd1);
        chk("err_nowrite_lit", 32'(mem_write), 32'd0);
        idle();
        chk("err_once_lit", 32'(dma_err), 32'd0);

        // Alternating CPU / DMA loads: rvalid alternates without gap or overlap
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1, 0, 32'h10, 32'd0, 0, 0, 32'd0, 32'd0, gc, gd);
            else            step(0, 0, 32'd0, 32'd0, 1, 0, 32'h10, 32'd0, gc, gd);
            chk("alt_cpu_rv", 32'(cpu_rvalid), 32'(i % 2 == 0));
            chk("alt_dma_rv", 32'(dma_rvalid), 32'(i % 2 == 1));
        end

        // Reset asserted in the cycle a CPU store is granted
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hBEEF;
        dma_req = 0;
        #1;
        chk("rst_pre_gnt", 32'(cpu_gnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_kill_gnt", 32'(cpu_gnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        check_regs();
        @(posedge clk); #1;
        check_regs();
        @(negedge clk); rst_n = 1'b1;
        cpu_req = 0;
        @(posedge clk); #1;
        check_regs();
        chk("rst_mem_kept", bmem[8'h0C], 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ca = 32'($urandom_range(0, 255)) << 2;
            da = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 15) == 0) ca = 32'h4000_0010;
            if ($urandom_range(0, 7) == 0)  da = ($urandom_range(0, 1) == 0) ? 32'h4000_0010 : 32'h8000_0020;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ca, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, $urandom, gc, gd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 STARVE_LIMIT, 4, consecutive cycles the DMA may be refused before it takes priority (range 1..15).
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cpu_req  in  1  CPU data-memory access request (load or store).
REQ-005 cpu_we  in  1  1 = store, 0 = load; qualified by cpu_req.
REQ-006 cpu_addr  in  32  CPU byte address.
REQ-007 cpu_wdata  in  32  CPU store data.
REQ-008 cpu_gnt  out  1  CPU request accepted this cycle (combinational).
REQ-009 cpu_rvalid  out  1  rdata holds the CPU load result this cycle.
REQ-010 dma_req  in  1  loader/DMA access request.
REQ-011 dma_we  in  1  1 = write, 0 = read; qualified by dma_req.
REQ-012 dma_addr  in  32  DMA byte address.
REQ-013 dma_wdata  in  32  DMA write data.
REQ-014 dma_gnt  out  1  DMA request accepted this cycle (combinational).
REQ-015 dma_rvalid  out  1  rdata holds the DMA read result this cycle.
REQ-016 dma_err  out  1  one-cycle pulse: accepted DMA access targeted a non-data region and was dropped.
REQ-017 mem_addr  out  32  address to the data memory, registered.
REQ-018 mem_wdata  out  32  write data to the data memory, registered.
REQ-019 mem_write  out  1  MemWrite to the data memory, registered.
REQ-020 mem_read  out  1  MemRead to the data memory, registered.
REQ-021 mem_rdata  in  32  ReadData from the data memory (combinational read).
REQ-022 rdata  out  32  mem_rdata passed straight through; shared by both requesters.

Function
REQ-023 Accept = req & gnt; at most one of cpu_gnt/dma_gnt is high in any cycle; one accept per cycle, back-to-back allowed.
REQ-024 Priority: CPU wins when both request, unless wait_cnt == STARVE_LIMIT, in which case DMA wins.
REQ-025 wait_cnt (4 bit): +1 each cycle dma_req & ~dma_gnt, saturating at STARVE_LIMIT; cleared on DMA accept or when dma_req is low.
REQ-026 A lone requester is granted in the same cycle, whatever wait_cnt is.
REQ-027 Accept in cycle N registers addr/wdata/we; mem_* are driven with that command in cycle N+1 only.
REQ-028 Owner FSM, registered each cycle: IDLE (no accept), CPU_CYC (CPU accepted), DMA_CYC (DMA accepted, data region), DMA_ERR (DMA accepted, non-data region).
REQ-029 In IDLE or DMA_ERR: mem_write = mem_read = 0 and mem_addr/mem_wdata hold their last values.
REQ-030 CPU_CYC: mem_write = we, mem_read = ~we; cpu_rvalid = ~we; all CPU addresses, including peripheral 0x4000_0010, are forwarded.
REQ-031 DMA_CYC is entered only if dma_addr[31:24] == 8'h00; mem_write = we, mem_read = ~we; dma_rvalid = ~we.
REQ-032 DMA_ERR is entered when dma_addr[31:24] != 8'h00; dma_err = 1 for that one cycle, no memory access, no dma_rvalid.
REQ-033 Load latency is exactly 1 cycle (accept N, rvalid N+1); writes give no acknowledgement beyond the grant.
REQ-034 cpu_rvalid and dma_rvalid are never high together; rdata is valid only while a rvalid is high.

Reset
REQ-035 Reset low asynchronously forces state IDLE, wait_cnt 0, mem_addr 0, mem_wdata 0, mem_write 0, mem_read 0 and the registered we 0; outputs stay there while reset is low.
REQ-036 Grants are forced 0 while reset is low; a command accepted in the cycle reset asserts is discarded and never reaches mem_*.
REQ-037 First grant is possible in the first cycle after reset deasserts.

Structure
REQ-038 Shared package holds the owner-state encoding, DATA_REGION = 8'h00 and the STARVE_LIMIT default.
REQ-039 Single flat module; the starvation counter is the only natural sub-module, dmem_starve_cnt.

Verification
REQ-040 CPU store to 0x0000_0010 with data 0x1234 -> cpu_gnt in N; N+1 mem_write 1, mem_addr 0x10; later CPU load of 0x10 -> cpu_rvalid in N+1, rdata 0x1234.
REQ-041 cpu_req and dma_req held high continuously, STARVE_LIMIT = 4 -> grant pattern CPU x4, DMA, CPU x4, DMA...
REQ-042 DMA write to 0x4000_0010 -> dma_gnt, dma_err pulses in N+1, mem_write stays 0.
REQ-043 Alternating CPU load / DMA load each cycle -> rvalid alternates with no gap and never overlaps.
REQ-044 Reset pulled low in the cycle a CPU store is granted -> no mem_write in any later cycle, all outputs 0.
